// File: rtl/dmem_port_if.sv
// dmem_port_if: core, DMA and data-memory signals of the shared memory port.
interface dmem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req, c_we, c_gnt, c_rvalid;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_we, stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd, mem_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rd,
        output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_wd, stall
    );
    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_wd, stall
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: core-first arbiter for the single data memory port with
// bounded DMA bursts and registered per-side read return.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic        clk,
    input logic        rst,
    dmem_port_if.slave bus
);
    localparam int RUN_W = $clog2(MAX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, CORE, DMA} owner_t;

    owner_t           owner;
    logic [RUN_W-1:0] run;
    logic             gc, gd;

    // Core wins unless it held the port last cycle or a DMA burst is still under its limit.
    always_comb begin
        gc = bus.c_req & (~bus.d_req | (owner == IDLE) | ((owner == DMA) & (run == RUN_MAX)));
        gd = bus.d_req & ~gc;
    end

    assign bus.c_gnt    = gc;
    assign bus.d_gnt    = gd;
    assign bus.stall    = bus.c_req & ~gc;
    assign bus.mem_we   = gc ? bus.c_we : gd ? bus.d_we : 1'b0;
    assign bus.mem_addr = gc ? ADDR_W'(bus.c_addr) : gd ? ADDR_W'(bus.d_addr) : '0;
    assign bus.mem_wd   = gc ? DATA_W'(bus.c_wdata) : gd ? DATA_W'(bus.d_wdata) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= IDLE;
            run          <= '0;
            bus.c_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.c_rdata  <= '0;
            bus.d_rdata  <= '0;
        end else begin
            owner        <= gc ? CORE : gd ? DMA : IDLE;
            run          <= !gd ? '0 : (owner != DMA) ? RUN_W'(1) : (run == RUN_MAX) ? run : run + 1'b1;
            bus.c_rvalid <= gc & ~bus.c_we;
            bus.d_rvalid <= gd & ~bus.d_we;
            if (gc & ~bus.c_we) bus.c_rdata <= bus.mem_rd;
            if (gd & ~bus.d_we) bus.d_rdata <= bus.mem_rd;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios with hand-computed expectations
// for grant order, memory mux, read return and async reset.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_rd = 0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1;
        #12;
        n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_c_rvalid got %0b want 0", bus.c_rvalid); end
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_d_rvalid got %0b want 0", bus.d_rvalid); end
        n_cmp++; if (bus.c_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_c_rdata got %h want 0", bus.c_rdata); end
        n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_d_rdata got %h want 0", bus.d_rdata); end
        rst = 0;
        next_cycle();
    endtask

    task automatic test_idle();
        clear_reqs();
        bus.c_addr = 32'h55; bus.d_addr = 32'h66; bus.c_wdata = 32'h77; bus.c_we = 1;
        #1;
        n_cmp++; if ({bus.c_gnt, bus.d_gnt, bus.stall, bus.mem_we} !== 4'b0) begin n_bad++; $display("FAIL idle_ctrl got %b want 0000", {bus.c_gnt, bus.d_gnt, bus.stall, bus.mem_we}); end
        n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0) begin n_bad++; $display("FAIL idle_mux got addr=%h wd=%h want 0/0", bus.mem_addr, bus.mem_wd); end
        next_cycle();
        n_cmp++; if (bus.c_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL idle_rvalid got %b%b want 00", bus.c_rvalid, bus.d_rvalid); end
        clear_reqs();
    endtask

    task automatic test_core_read();
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.mem_rd = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_bad++; $display("FAIL crd_gnt got c=%b d=%b want 1/0", bus.c_gnt, bus.d_gnt); end
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL crd_mux got we=%b addr=%h want 0/10", bus.mem_we, bus.mem_addr); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL crd_stall0 got %b want 0", bus.stall); end
        next_cycle();
        bus.c_req = 0; bus.mem_rd = 32'h0BAD0BAD;
        #1;
        n_cmp++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL crd_data got v=%b d=%h want 1/deadbeef", bus.c_rvalid, bus.c_rdata); end
        n_cmp++; if (bus.stall !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL crd_stall1 got s=%b dv=%b want 0/0", bus.stall, bus.d_rvalid); end
        next_cycle();
        n_cmp++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL crd_hold got v=%b d=%h want 0/deadbeef", bus.c_rvalid, bus.c_rdata); end
        clear_reqs();
    endtask

    task automatic test_core_write();
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h20; bus.c_wdata = 32'h1234; bus.mem_rd = 32'hFFFF0000;
        #1;
        n_cmp++; if (bus.c_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL cwr_gnt got g=%b we=%b want 1/1", bus.c_gnt, bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h20 || bus.mem_wd !== 32'h1234) begin n_bad++; $display("FAIL cwr_mux got addr=%h wd=%h want 20/1234", bus.mem_addr, bus.mem_wd); end
        next_cycle();
        bus.c_req = 0;
        #1;
        n_cmp++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cwr_norv got v=%b d=%h want 0/deadbeef", bus.c_rvalid, bus.c_rdata); end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_both_held();
        logic [10:0] want_c;
        want_c = 11'b10000100001;  // MSB first: C,D,D,D,D,C,D,D,D,D,C
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'hC0; bus.c_wdata = 32'hC;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'hD0; bus.d_wdata = 32'hD;
        for (int i = 0; i < 11; i++) begin
            #1;
            n_cmp++;
            if (bus.c_gnt !== want_c[10-i] || bus.d_gnt !== !want_c[10-i] || bus.stall !== !want_c[10-i]) begin
                n_bad++; $display("FAIL both_seq[%0d] got c=%b d=%b stall=%b want c=%b", i, bus.c_gnt, bus.d_gnt, bus.stall, want_c[10-i]);
            end
            n_cmp++;
            if (bus.mem_addr !== (want_c[10-i] ? 32'hC0 : 32'hD0)) begin
                n_bad++; $display("FAIL both_addr[%0d] got %h want %h", i, bus.mem_addr, want_c[10-i] ? 32'hC0 : 32'hD0);
            end
            next_cycle();
        end
        clear_reqs();
        next_cycle();
    endtask

    task automatic test_dma_burst();
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200 + i; bus.mem_rd = 32'hA000 + i;
            end else begin
                clear_reqs();
            end
            #1;
            if (i > 0) begin
                n_cmp++;
                if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA000 + i - 1) begin
                    n_bad++; $display("FAIL dma_data[%0d] got v=%b d=%h want 1/%h", i, bus.d_rvalid, bus.d_rdata, 32'hA000 + i - 1);
                end
            end
            if (i < 6) begin
                n_cmp++;
                if (bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h200 + i || bus.stall !== 1'b0) begin
                    n_bad++; $display("FAIL dma_gnt[%0d] got g=%b addr=%h s=%b want 1/%h/0", i, bus.d_gnt, bus.mem_addr, bus.stall, 32'h200 + i);
                end
            end
            next_cycle();
        end
        n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'hA005) begin n_bad++; $display("FAIL dma_end got v=%b d=%h want 0/a005", bus.d_rvalid, bus.d_rdata); end
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.mem_rd = 32'h5A5A5A5A;
        next_cycle();
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL rmid_pre got v=%b d=%h want 1/5a5a5a5a", bus.d_rvalid, bus.d_rdata); end
        #1 rst = 1;
        #1;
        n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_async got v=%b d=%h want 0/0", bus.d_rvalid, bus.d_rdata); end
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h44; bus.mem_rd = 32'h12345678;
        #1;
        n_cmp++; if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_bad++; $display("FAIL rmid_inrst got c=%b d=%b want 1/0", bus.c_gnt, bus.d_gnt); end
        next_cycle();
        n_cmp++; if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_drop got v=%b d=%h want 0/0", bus.c_rvalid, bus.c_rdata); end
        rst = 0;
        #1;
        n_cmp++; if (bus.c_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_addr !== 32'h44) begin n_bad++; $display("FAIL rmid_first got c=%b d=%b addr=%h want 1/0/44", bus.c_gnt, bus.d_gnt, bus.mem_addr); end
        next_cycle();
        n_cmp++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rmid_crd got v=%b d=%h want 1/12345678", bus.c_rvalid, bus.c_rdata); end
        n_cmp++; if (bus.d_gnt !== 1'b1 || bus.stall !== 1'b1) begin n_bad++; $display("FAIL rmid_second got d=%b s=%b want 1/1", bus.d_gnt, bus.stall); end
        clear_reqs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_core_read();
        test_core_write();
        test_idle();
        test_both_held();
        test_dma_burst();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout reached without completing the test sequence");
        $fatal(1, "timeout");
    end
endmodule
